// File: rtl/nios_busy_sequencer.sv
// nios_busy_sequencer: Avalon-MM command queue that issues 32-bit commands
// one at a time to a shared datapath over a start/done handshake.
module nios_busy_sequencer #(
    parameter int unsigned DEPTH   = 4,
    parameter int unsigned TIMEOUT = 1024
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [1:0]  address,
    input  logic        chipselect,
    input  logic        write_n,
    input  logic [31:0] writedata,
    output logic [31:0] readdata,
    output logic [31:0] dp_cmd,
    output logic        dp_start,
    input  logic        dp_done,
    input  logic [31:0] dp_result,
    output logic        busy
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = PW + 1;
    localparam int unsigned TW = 16;
    localparam bit          TO_EN   = (TIMEOUT != 0);
    localparam logic [TW-1:0] TO_LAST = (TIMEOUT == 0) ? TW'(0) : TW'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2
    } state_t;

    state_t          r_state;
    state_t          w_state_nxt;
    logic [31:0]     r_mem [DEPTH];
    logic [PW-1:0]   r_wptr;
    logic [PW-1:0]   r_rptr;
    logic [CW-1:0]   r_count;
    logic [TW-1:0]   r_timer;
    logic [15:0]     r_done_count;
    logic [31:0]     r_result;
    logic            r_overflow;
    logic            r_timeout;
    logic [31:0]     r_readdata;
    logic [31:0]     r_dp_cmd;
    logic            r_dp_start;

    logic            w_wr;
    logic            w_push_req;
    logic            w_clr_wr;
    logic            w_flush;
    logic            w_abort;
    logic            w_empty;
    logic            w_full;
    logic            w_push;
    logic            w_ovf_set;
    logic            w_pop;
    logic            w_done_acc;
    logic            w_to_hit;
    logic            w_timer_clr;
    logic            w_timer_inc;
    logic [31:0]     w_status;

    // Bus write decode; flush beats a push landing in the same cycle.
    assign w_wr       = chipselect & ~write_n;
    assign w_push_req = w_wr && (address == 2'd0);
    assign w_clr_wr   = w_wr && (address == 2'd1);
    assign w_flush    = w_wr && (address == 2'd2) && writedata[0];
    assign w_abort    = w_wr && (address == 2'd2) && writedata[1];
    assign w_empty    = (r_count == CW'(0));
    assign w_full     = (r_count == CW'(DEPTH));
    assign w_push     = w_push_req & ~w_flush & ~w_full;
    assign w_ovf_set  = w_push_req & ~w_flush & w_full;

    // State register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) r_state <= ST_IDLE;
        else          r_state <= w_state_nxt;
    end

    // Next-state and handshake control; abort > done > timeout inside WAIT.
    always_comb begin
        w_state_nxt = r_state;
        w_pop       = 1'b0;
        w_done_acc  = 1'b0;
        w_to_hit    = 1'b0;
        w_timer_clr = 1'b0;
        w_timer_inc = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (!w_empty) begin
                    w_pop       = 1'b1;
                    w_timer_clr = 1'b1;
                    w_state_nxt = ST_ISSUE;
                end
            end
            ST_ISSUE: w_state_nxt = ST_WAIT;
            ST_WAIT: begin
                if (w_abort) begin
                    w_state_nxt = ST_IDLE;
                end else if (dp_done) begin
                    w_done_acc  = 1'b1;
                    w_state_nxt = ST_IDLE;
                end else if (TO_EN && (r_timer == TO_LAST)) begin
                    w_to_hit    = 1'b1;
                    w_state_nxt = ST_IDLE;
                end else begin
                    w_timer_inc = 1'b1;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // FIFO storage; contents need no reset because count gates every read.
    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wptr] <= writedata;
    end

    // FIFO pointers and occupancy; flush empties the queue but the head popped this cycle still issues.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else if (w_flush) begin
            r_rptr  <= r_wptr;
            r_count <= '0;
        end else begin
            if (w_push) r_wptr <= r_wptr + PW'(1);
            if (w_pop)  r_rptr <= r_rptr + PW'(1);
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Datapath command, start pulse and WAIT watchdog.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_dp_cmd   <= '0;
            r_dp_start <= 1'b0;
            r_timer    <= '0;
        end else begin
            if (w_pop) r_dp_cmd <= r_mem[r_rptr];
            r_dp_start <= (w_state_nxt == ST_ISSUE);
            if (w_timer_clr)      r_timer <= '0;
            else if (w_timer_inc) r_timer <= r_timer + TW'(1);
        end
    end

    // Completion counter, captured result and sticky flags; a set beats a same-cycle clear.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_done_count <= '0;
            r_result     <= '0;
            r_overflow   <= 1'b0;
            r_timeout    <= 1'b0;
        end else begin
            if (w_done_acc)                     r_done_count <= r_done_count + 16'd1;
            else if (w_clr_wr && writedata[0])  r_done_count <= '0;
            if (w_done_acc)                     r_result <= dp_result;
            if (w_ovf_set)                      r_overflow <= 1'b1;
            else if (w_clr_wr && writedata[3])  r_overflow <= 1'b0;
            if (w_to_hit)                       r_timeout <= 1'b1;
            else if (w_clr_wr && writedata[4])  r_timeout <= 1'b0;
        end
    end

    // Status word layout.
    always_comb begin
        w_status        = '0;
        w_status[0]     = busy;
        w_status[1]     = w_empty;
        w_status[2]     = w_full;
        w_status[3]     = r_overflow;
        w_status[4]     = r_timeout;
        w_status[15:8]  = 8'(r_count);
        w_status[17:16] = r_state;
    end

    // Read mux, registered every clock regardless of chipselect.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_readdata <= '0;
        end else begin
            case (address)
                2'd0:    r_readdata <= w_status;
                2'd1:    r_readdata <= {16'd0, r_done_count};
                2'd2:    r_readdata <= '0;
                default: r_readdata <= r_result;
            endcase
        end
    end

    assign readdata = r_readdata;
    assign dp_cmd   = r_dp_cmd;
    assign dp_start = r_dp_start;
    assign busy     = ~w_empty | (r_state != ST_IDLE);

endmodule

// File: tb/tb_nios_busy_sequencer.sv
// Self-checking bench for nios_busy_sequencer: register table, directed corner
// sequences and a randomized phase against a transaction-level model.
module tb_nios_busy_sequencer;

    localparam int unsigned DEPTH   = 4;
    localparam int unsigned TIMEOUT = 16;

    logic        clk;
    logic        reset_n;
    logic [1:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [31:0] writedata;
    logic [31:0] readdata;
    logic [31:0] dp_cmd;
    logic        dp_start;
    logic        dp_done;
    logic [31:0] dp_result;
    logic        busy;

    nios_busy_sequencer #(.DEPTH(DEPTH), .TIMEOUT(TIMEOUT)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .address    (address),
        .chipselect (chipselect),
        .write_n    (write_n),
        .writedata  (writedata),
        .readdata   (readdata),
        .dp_cmd     (dp_cmd),
        .dp_start   (dp_start),
        .dp_done    (dp_done),
        .dp_result  (dp_result),
        .busy       (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int          n_pass;
    int          n_total;
    logic [31:0] exp_q [$];
    int          n_starts;
    bit          resp_en;
    bit          resp_rand;
    int          resp_delay;
    bit          resp_busy;

    typedef struct {
        bit          wr;
        logic [1:0]  addr;
        logic [31:0] data;
        logic [31:0] exp;
    } vec_t;
    vec_t tbl [10];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h required 0x%08h", name, act, exp);
    endtask

    // Reference datapath function used by both the responder and the model.
    function automatic logic [31:0] dp_func(input logic [31:0] c);
        return (c ^ 32'hA5A5_0000) + 32'h0000_1233;
    endfunction

    // Datapath model: logs every start, checks command order, answers with done when enabled.
    initial begin
        logic [31:0] cmd;
        int d;
        dp_done   = 1'b0;
        dp_result = '0;
        resp_busy = 1'b0;
        forever begin
            @(negedge clk);
            if (reset_n && dp_start) begin
                n_starts++;
                cmd = dp_cmd;
                check("start_queued", 32'(exp_q.size() > 0), 32'd1);
                if (exp_q.size() > 0) check("start_cmd", cmd, exp_q.pop_front());
                if (resp_en) begin
                    resp_busy = 1'b1;
                    d = resp_rand ? int'($urandom_range(0, 4)) : resp_delay;
                    @(negedge clk);
                    repeat (d) @(negedge clk);
                    dp_done   = 1'b1;
                    dp_result = dp_func(cmd);
                    @(negedge clk);
                    dp_done   = 1'b0;
                    dp_result = $urandom;
                    resp_busy = 1'b0;
                end
            end
        end
    end

    task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
        @(negedge clk);
        chipselect = 1'b1; write_n = 1'b0; address = a; writedata = d;
        @(negedge clk);
        chipselect = 1'b0; write_n = 1'b1;
    endtask

    task automatic bus_read(input logic [1:0] a, output logic [31:0] d);
        @(negedge clk);
        address = a; chipselect = 1'b0; write_n = 1'b1;
        @(negedge clk);
        d = readdata;
    endtask

    // Pushes on consecutive clock edges.
    task automatic push_burst(input int n, input logic [31:0] base);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            chipselect = 1'b1; write_n = 1'b0; address = 2'd0; writedata = base + 32'(i);
        end
        @(negedge clk);
        chipselect = 1'b0; write_n = 1'b1;
    endtask

    task automatic wait_idle(input int maxc);
        int c = 0;
        while ((busy || resp_busy) && c < maxc) begin
            @(negedge clk);
            c++;
        end
        check("idle_reached", 32'(!(busy || resp_busy)), 32'd1);
    endtask

    task automatic wait_start(input int maxc);
        int c = 0;
        while (!dp_start && c < maxc) begin
            @(negedge clk);
            c++;
        end
        check("start_seen", 32'(dp_start), 32'd1);
    endtask

    initial begin
        logic [31:0] rd;
        logic [31:0] w;
        logic [31:0] model_last;
        int          model_done;
        int          base;
        int          cnt;
        int          k;

        n_pass = 0; n_total = 0; n_starts = 0;
        resp_en = 1'b0; resp_rand = 1'b0; resp_delay = 1;
        reset_n = 1'b0; chipselect = 1'b0; write_n = 1'b1; address = '0; writedata = '0;

        tbl[0] = '{1'b0, 2'd0, 32'h0,        32'h0000_0002};
        tbl[1] = '{1'b0, 2'd1, 32'h0,        32'h0};
        tbl[2] = '{1'b0, 2'd2, 32'h0,        32'h0};
        tbl[3] = '{1'b0, 2'd3, 32'h0,        32'h0};
        tbl[4] = '{1'b1, 2'd3, 32'hFFFF_FFFF, 32'h0};
        tbl[5] = '{1'b0, 2'd0, 32'h0,        32'h0000_0002};
        tbl[6] = '{1'b1, 2'd1, 32'h0000_0019, 32'h0};
        tbl[7] = '{1'b0, 2'd1, 32'h0,        32'h0};
        tbl[8] = '{1'b1, 2'd2, 32'h0000_0003, 32'h0};
        tbl[9] = '{1'b0, 2'd0, 32'h0,        32'h0000_0002};

        repeat (3) @(negedge clk);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_start", 32'(dp_start), 32'd0);
        check("rst_cmd", dp_cmd, 32'd0);
        check("rst_readdata", readdata, 32'd0);
        reset_n = 1'b1;

        // Register map table after reset.
        for (int i = 0; i < 10; i++) begin
            if (tbl[i].wr) bus_write(tbl[i].addr, tbl[i].data);
            else begin
                bus_read(tbl[i].addr, rd);
                check($sformatf("tbl%0d", i), rd, tbl[i].exp);
            end
        end
        check("tbl_no_start", 32'(n_starts), 32'd0);

        // Single command with issue timing.
        resp_en = 1'b1; resp_delay = 1; base = n_starts;
        exp_q.push_back(32'hA5A5_0001);
        bus_write(2'd0, 32'hA5A5_0001);
        check("push_busy", 32'(busy), 32'd1);
        check("push_start_lat", 32'(dp_start), 32'd0);
        @(negedge clk);
        check("issue_start", 32'(dp_start), 32'd1);
        check("issue_cmd", dp_cmd, 32'hA5A5_0001);
        wait_idle(50);
        bus_read(2'd1, rd); check("single_done_cnt", rd, 32'd1);
        bus_read(2'd3, rd); check("single_result", rd, 32'h0000_1234);
        check("single_busy", 32'(busy), 32'd0);
        check("single_starts", 32'(n_starts - base), 32'd1);

        // Overflow with a stalled datapath, then watchdog timeouts.
        resp_en = 1'b0; base = n_starts;
        for (int i = 0; i < 5; i++) exp_q.push_back(32'hB000_0000 + 32'(i));
        push_burst(6, 32'hB000_0000);
        bus_read(2'd0, rd); check("ovf_status", rd, 32'h0002_040D);
        bus_write(2'd1, 32'h8);
        bus_read(2'd0, rd); check("ovf_cleared", rd, 32'h0002_0405);
        wait_start(60);
        cnt = 0;
        do begin
            @(negedge clk);
            cnt++;
        end while (!dp_start && cnt < 100);
        check("timeout_gap", 32'(cnt), 32'(TIMEOUT + 2));
        bus_write(2'd2, 32'h1);
        exp_q.delete();
        bus_write(2'd2, 32'h2);
        wait_idle(50);
        bus_read(2'd0, rd); check("to_status", rd, 32'h0000_0012);
        bus_read(2'd1, rd); check("to_done_cnt", rd, 32'd1);
        bus_write(2'd1, 32'h10);
        bus_read(2'd0, rd); check("to_cleared", rd, 32'h0000_0002);
        check("to_starts", 32'(n_starts - base), 32'd3);

        // Queue then flush and abort during WAIT.
        base = n_starts;
        exp_q.push_back(32'hC0DE_0001);
        bus_write(2'd0, 32'hC0DE_0001);
        wait_start(10);
        bus_write(2'd0, 32'hC0DE_0002);
        bus_write(2'd0, 32'hC0DE_0003);
        bus_write(2'd2, 32'h1);
        bus_write(2'd2, 32'h2);
        wait_idle(20);
        repeat (20) @(negedge clk);
        bus_read(2'd0, rd); check("flush_status", rd, 32'h0000_0002);
        check("flush_starts", 32'(n_starts - base), 32'd1);

        // Asynchronous reset while waiting with entries queued.
        exp_q.push_back(32'hD000_0000);
        push_burst(4, 32'hD000_0000);
        #2 reset_n = 1'b0;
        #1;
        check("arst_start", 32'(dp_start), 32'd0);
        check("arst_busy", 32'(busy), 32'd0);
        check("arst_cmd", dp_cmd, 32'd0);
        check("arst_readdata", readdata, 32'd0);
        exp_q.delete();
        base = n_starts;
        @(negedge clk);
        reset_n = 1'b1;
        repeat (20) @(negedge clk);
        check("arst_no_start", 32'(n_starts - base), 32'd0);
        bus_read(2'd0, rd); check("arst_status", rd, 32'h0000_0002);
        bus_read(2'd1, rd); check("arst_done_cnt", rd, 32'd0);

        // Randomized batches against the transaction model.
        resp_en = 1'b1; resp_rand = 1'b1;
        model_done = 0; model_last = '0;
        for (int b = 0; b < 20; b++) begin
            k = int'($urandom_range(1, DEPTH));
            for (int i = 0; i < k; i++) begin
                w = $urandom;
                exp_q.push_back(w);
                repeat ($urandom_range(0, 2)) @(negedge clk);
                bus_write(2'd0, w);
                model_done++;
                model_last = dp_func(w);
            end
            wait_idle(300);
            bus_read(2'd1, rd); check("rnd_done_cnt", rd, 32'(model_done & 16'hFFFF));
            bus_read(2'd3, rd); check("rnd_result", rd, model_last);
            bus_read(2'd0, rd); check("rnd_status", rd, 32'h0000_0002);
        end
        check("rnd_queue_drained", 32'(exp_q.size()), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
